m_layer_pool_2: RTL and testbench

Downstream max-pooling reducer for the second pooling layer. Consumes the window-ordered sample stream produced by the pooling input buffer (`map_out`/`k_ready` of that stage), reduces every `WIN_LEN` consecutive valid samples to their signed maximum, and emits one result per window together with a write strobe and write address for the next layer's input RAM. It also drives a frame-level `ready` flag that the following layer uses as its enable/reset.

---
 rtl/m_pool_pkg.sv | 18 +
 rtl/m_layer_pool_2_if.sv | 25 ++
 rtl/m_max_sel.sv | 14 +
 rtl/m_layer_pool_2.sv | 101 ++++++++++
 tb/tb_m_layer_pool_2.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/m_pool_pkg.sv
// Shared pooling definitions: FSM states and default geometry common to the
// pooling input buffer and the pool reducers.
package m_pool_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_K_SIDE   = 5;
  localparam int DEF_OUT_SIDE = 18;
  localparam int DEF_WIN_LEN  = DEF_K_SIDE * DEF_K_SIDE;
  localparam int DEF_NUM_OUT  = DEF_OUT_SIDE * DEF_OUT_SIDE;
  localparam int DEF_ADDR_W   = 9;

endpackage

// File: rtl/m_layer_pool_2_if.sv
// Sample-in / window-result-out bundle of the second pooling layer.
interface m_layer_pool_2_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [DATA_W-1:0] map_in;
  logic              in_valid;
  logic [DATA_W-1:0] map_out;
  logic              wr;
  logic [ADDR_W-1:0] addr_out;
  logic              ready;
  logic              frame_done;

  // Upstream sample source / downstream RAM writer side.
  modport master (
    output map_in, in_valid,
    input  map_out, wr, addr_out, ready, frame_done
  );

  // Pool reducer side.
  modport slave (
    input  map_in, in_valid,
    output map_out, wr, addr_out, ready, frame_done
  );
endinterface

// File: rtl/m_max_sel.sv
// Combinational signed two-input max with load select: y = load ? b : max(a, b).
// Ties keep a, so an accumulator on input a is only replaced by a strictly larger b.
module m_max_sel #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     load,
  output logic signed [DATA_W-1:0] y
);

  assign y = (load || (b > a)) ? b : a;

endmodule

// File: rtl/m_layer_pool_2.sv
// Second-layer max-pool reducer: every WIN_LEN valid samples -> one signed max,
// written with a window address. Define M_POOL_RELU_EN to clamp negative results to 0.
module m_layer_pool_2
  import m_pool_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic            clk_in,
  input  logic            rst_n,
  m_layer_pool_2_if.slave bus
);

  localparam int CNT_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0]  LAST_ELEM = CNT_W'(WIN_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_WIN  = ADDR_W'(NUM_OUT - 1);

  state_t                    state;
  logic signed [DATA_W-1:0]  acc;
  logic signed [DATA_W-1:0]  sel;
  logic signed [DATA_W-1:0]  pool_val;
  logic [CNT_W-1:0]          elem_cnt;
  logic [ADDR_W-1:0]         win_cnt;
  logic                      load;

  // The first sample of every window is taken as-is, so no -inf seed is needed.
  assign load = (state == IDLE) || (elem_cnt == '0);

  m_max_sel #(.DATA_W(DATA_W)) u_max_sel (
    .a    (acc),
    .b    (bus.map_in),
    .load (load),
    .y    (sel)
  );

`ifdef M_POOL_RELU_EN
  assign pool_val = sel[DATA_W-1] ? '0 : sel;
`else
  assign pool_val = sel;
`endif

  // NOTE: every register, including the accumulator datapath, is cleared by the
  // async reset so a partial window can never leak into the next frame.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc            <= '0;
      elem_cnt       <= '0;
      win_cnt        <= '0;
      bus.map_out    <= '0;
      bus.wr         <= 1'b0;
      bus.addr_out   <= '0;
      bus.ready      <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; strobes default low and are
      // overridden below in the cycle a window completes.
      bus.wr         <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            acc       <= sel;
            elem_cnt  <= CNT_W'(1);
            win_cnt   <= '0;
            bus.ready <= 1'b0;
            state     <= ACC;
          end
        end
        ACC: begin
          if (bus.in_valid) begin
            acc <= sel;
            if (elem_cnt == LAST_ELEM) begin
              elem_cnt     <= '0;
              bus.wr       <= 1'b1;
              bus.map_out  <= pool_val;
              bus.addr_out <= win_cnt;
              if (win_cnt == LAST_WIN) begin
                win_cnt        <= '0;
                bus.frame_done <= 1'b1;
                bus.ready      <= 1'b1;
                state          <= DONE;
              end else begin
                win_cnt <= win_cnt + 1'b1;
              end
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (!bus.in_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_layer_pool_2.sv
// Self-checking bench for m_layer_pool_2: ramp, special windows, bubbles,
// frame end, and asynchronous reset, checked against a window-max model.
module tb_m_layer_pool_2;

  localparam int DATA_W  = 16;
  localparam int WIN_LEN = 25;
  localparam int NUM_OUT = 324;
  localparam int ADDR_W  = 9;

  logic clk;
  logic rst_n;

  m_layer_pool_2_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  m_layer_pool_2 #(
    .DATA_W (DATA_W),
    .WIN_LEN(WIN_LEN),
    .NUM_OUT(NUM_OUT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_in(clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  logic signed [DATA_W-1:0] win_buf [WIN_LEN];
  int                       exp_addr;
  logic [DATA_W-1:0]        prev_out;
  logic [ADDR_W-1:0]        prev_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then sample outputs 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [DATA_W-1:0] d);
    bus.in_valid = v;
    bus.map_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, "_wr"},    32'(bus.wr), 32'd0);
    check({tag, "_fdone"}, 32'(bus.frame_done), 32'd0);
    check({tag, "_ready"}, 32'(bus.ready), 32'(exp_ready));
    check({tag, "_hold"},  32'(bus.map_out), 32'(prev_out));
    check({tag, "_ahold"}, 32'(bus.addr_out), 32'(prev_addr));
  endtask

  // Model: the expected result is simply the signed max of win_buf.
  task automatic send_window(input bit bubbles);
    int                m;
    logic [DATA_W-1:0] exp_out;
    bit                last;
    m = int'(win_buf[0]);
    for (int i = 1; i < WIN_LEN; i++)
      if (int'(win_buf[i]) > m) m = int'(win_buf[i]);
`ifdef M_POOL_RELU_EN
    if (m < 0) m = 0;
`endif
    exp_out = DATA_W'(m);
    last    = (exp_addr == NUM_OUT - 1);
    for (int i = 0; i < WIN_LEN; i++) begin
      if (bubbles && i > 0)
        for (int b = 0; b < 3 && $urandom_range(0, 1) == 1; b++) begin
          cyc(1'b0, DATA_W'($urandom));
          check_quiet("bubble", 1'b0);
        end
      cyc(1'b1, win_buf[i]);
      if (i < WIN_LEN - 1) begin
        check_quiet("mid", 1'b0);
      end else begin
        check("win_wr",    32'(bus.wr), 32'd1);
        check("win_max",   32'(bus.map_out), 32'(exp_out));
        check("win_addr",  32'(bus.addr_out), 32'(exp_addr));
        check("win_fdone", 32'(bus.frame_done), 32'(last));
        check("win_ready", 32'(bus.ready), 32'(last));
        prev_out  = exp_out;
        prev_addr = ADDR_W'(exp_addr);
      end
    end
    exp_addr = last ? 0 : exp_addr + 1;
  endtask

  // kind 0: ramp; kind 1: directed special windows then random; kind 2: random.
  task automatic send_frame(input int kind);
    cyc(1'b0, '0);
    check("idle_ready", 32'(bus.ready), 32'd1);
    for (int w = 0; w < NUM_OUT; w++) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        if (kind == 0)
          win_buf[i] = DATA_W'(w * 2 + (i * 11) % WIN_LEN);
        else
          win_buf[i] = DATA_W'($urandom);
      end
      if (kind == 1 && w == 0)
        for (int i = 0; i < WIN_LEN; i++) win_buf[i] = DATA_W'(-32768 + i);
      if (kind == 1 && w == 1) begin
        win_buf[0] = 16'sd5;
        win_buf[1] = -16'sd3;
        win_buf[2] = 16'sd17;
        for (int i = 3; i < WIN_LEN; i++) win_buf[i] = DATA_W'(int'($urandom_range(0, 36)) - 20);
      end
      if (kind == 1 && w == 2)
        for (int i = 0; i < WIN_LEN; i++) win_buf[i] = 16'sd100;
      if (kind == 1 && w == 3)
        for (int i = 0; i < WIN_LEN; i++) win_buf[i] = (i == 0) ? 16'sd7 : 16'sd3;
      send_window(kind != 0 && (w == 1 || w % 7 == 3));
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.map_in   = '0;
    exp_addr     = 0;
    prev_out     = '0;
    prev_addr    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_map",   32'(bus.map_out), 32'd0);
    check("rst_wr",    32'(bus.wr), 32'd0);
    check("rst_addr",  32'(bus.addr_out), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_fdone", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;

    send_frame(0);
    send_frame(1);

    // Samples after the last window are ignored until in_valid drops.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, DATA_W'($urandom));
      check_quiet("post", 1'b1);
    end

    send_frame(2);

    // Partial frame then asynchronous reset 12 samples into window 5.
    cyc(1'b0, '0);
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < WIN_LEN; i++) win_buf[i] = DATA_W'($urandom);
      send_window(1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, DATA_W'($urandom));
      check_quiet("part", 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_map",   32'(bus.map_out), 32'd0);
    check("arst_wr",    32'(bus.wr), 32'd0);
    check("arst_addr",  32'(bus.addr_out), 32'd0);
    check("arst_ready", 32'(bus.ready), 32'd1);
    check("arst_fdone", 32'(bus.frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_addr  = 0;
    prev_out  = '0;
    prev_addr = '0;

    send_frame(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
